// File: rtl/regfile_pkg.sv
// Shared register-file constants and the port-controller state encoding.
package regfile_pkg;

   localparam int unsigned DATA_W = 32;
   localparam int unsigned ADDR_W = 5;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      FETCH   = 2'd1,
      PRESENT = 2'd2
   } state_t;

endpackage

// File: rtl/operand_bypass.sv
// Per-source operand tracker: holds the source index, an accept-cycle
// writeback bypass, and the operand presented to execute.
module operand_bypass #(
   parameter int unsigned DATA_W = regfile_pkg::DATA_W,
   parameter int unsigned ADDR_W = regfile_pkg::ADDR_W
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              capture,
   input  logic              fetch,
   input  logic              hold,
   input  logic [ADDR_W-1:0] src,
   input  logic              wb_valid,
   input  logic [ADDR_W-1:0] wb_rd,
   input  logic [DATA_W-1:0] wb_data,
   input  logic [DATA_W-1:0] rf_data,
   output logic [DATA_W-1:0] operand
);

   logic [ADDR_W-1:0] idx;
   logic              byp;
   logic [DATA_W-1:0] byp_data;
   logic              src_hit_c;
   logic              idx_hit_c;
   logic [DATA_W-1:0] fetch_val_c;

   // Writeback matches against the incoming source and the held source; x0 never matches.
   always_comb begin
      src_hit_c = wb_valid && (wb_rd == src) && (src != '0);
      idx_hit_c = wb_valid && (wb_rd == idx) && (idx != '0);
   end

   // Operand value at the end of the read: zero index, then live writeback, then bypass, then rf.
   always_comb begin
      fetch_val_c = rf_data;
      if (idx == '0) begin
         fetch_val_c = '0;
      end else if (idx_hit_c) begin
         fetch_val_c = wb_data;
      end else if (byp) begin
         fetch_val_c = byp_data;
      end
   end

   // Index and bypass capture on accept; a same-cycle writeback is invisible to the rf read.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         idx      <= '0;
         byp      <= 1'b0;
         byp_data <= '0;
      end else if (capture) begin
         idx <= src;
         byp <= src_hit_c;
         if (src_hit_c) begin
            byp_data <= wb_data;
         end
      end
   end

   // Held operand: loaded at the end of the read, kept coherent with writebacks while presented.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         operand <= '0;
      end else if (fetch) begin
         operand <= fetch_val_c;
      end else if (hold && idx_hit_c) begin
         operand <= wb_data;
      end
   end

endmodule

// File: rtl/regfile_port_ctrl.sv
// Register-file port controller: issue handshake, one-cycle read latency,
// RAW resolution against writeback, and operand presentation to execute.
module regfile_port_ctrl #(
   parameter int unsigned DATA_W = regfile_pkg::DATA_W,
   parameter int unsigned ADDR_W = regfile_pkg::ADDR_W
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              iss_valid,
   output logic              iss_ready,
   input  logic [ADDR_W-1:0] iss_rs1,
   input  logic [ADDR_W-1:0] iss_rs2,
   input  logic [ADDR_W-1:0] iss_rd,
   output logic              op_valid,
   input  logic              op_ready,
   output logic [DATA_W-1:0] op_rs1_data,
   output logic [DATA_W-1:0] op_rs2_data,
   output logic [ADDR_W-1:0] op_rd,
   input  logic              wb_valid,
   input  logic [ADDR_W-1:0] wb_rd,
   input  logic [DATA_W-1:0] wb_data,
   output logic [ADDR_W-1:0] rf_rs1,
   output logic [ADDR_W-1:0] rf_rs2,
   input  logic [DATA_W-1:0] rf_rs1_data,
   input  logic [DATA_W-1:0] rf_rs2_data,
   output logic [ADDR_W-1:0] rf_rd,
   output logic [DATA_W-1:0] rf_write_data,
   output logic              rf_write_enable
);

   import regfile_pkg::*;

   state_t state;
   state_t state_next;
   logic   accept_c;
   logic   in_fetch_c;
   logic   in_present_c;

   // State register; op_valid is registered alongside it.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state    <= IDLE;
         op_valid <= 1'b0;
      end else begin
         state    <= state_next;
         op_valid <= (state_next == PRESENT);
      end
   end

   // Next state, issue ready and accept strobe.
   always_comb begin
      state_next = state;
      iss_ready  = 1'b0;
      accept_c   = 1'b0;
      case (state)
         IDLE: begin
            iss_ready = 1'b1;
            if (iss_valid) begin
               accept_c   = 1'b1;
               state_next = FETCH;
            end
         end
         FETCH: begin
            state_next = PRESENT;
         end
         PRESENT: begin
            if (op_ready) begin
               iss_ready = 1'b1;
               if (iss_valid) begin
                  accept_c   = 1'b1;
                  state_next = FETCH;
               end else begin
                  state_next = IDLE;
               end
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Destination index travels with the operation.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         op_rd <= '0;
      end else if (accept_c) begin
         op_rd <= iss_rd;
      end
   end

   // Read addresses and write port pass straight through; x0 is never written.
   always_comb begin
      rf_rs1          = iss_rs1;
      rf_rs2          = iss_rs2;
      rf_rd           = wb_rd;
      rf_write_data   = wb_data;
      rf_write_enable = wb_valid && (wb_rd != '0);
      in_fetch_c      = (state == FETCH);
      in_present_c    = (state == PRESENT);
   end

   operand_bypass #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
   ) u_rs1 (
      .clk      (clk),
      .resetn   (resetn),
      .capture  (accept_c),
      .fetch    (in_fetch_c),
      .hold     (in_present_c),
      .src      (iss_rs1),
      .wb_valid (wb_valid),
      .wb_rd    (wb_rd),
      .wb_data  (wb_data),
      .rf_data  (rf_rs1_data),
      .operand  (op_rs1_data)
   );

   operand_bypass #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
   ) u_rs2 (
      .clk      (clk),
      .resetn   (resetn),
      .capture  (accept_c),
      .fetch    (in_fetch_c),
      .hold     (in_present_c),
      .src      (iss_rs2),
      .wb_valid (wb_valid),
      .wb_rd    (wb_rd),
      .wb_data  (wb_data),
      .rf_data  (rf_rs2_data),
      .operand  (op_rs2_data)
   );

endmodule

// File: tb/tb_regfile_port_ctrl.sv
// Bench for regfile_port_ctrl: behavioural register file, architectural-state
// model with an occupancy pipeline, per-cycle compare plus directed literals.
module tb_regfile_port_ctrl;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic        iss_valid = 1'b0;
   logic        iss_ready;
   logic [4:0]  iss_rs1 = '0;
   logic [4:0]  iss_rs2 = '0;
   logic [4:0]  iss_rd = '0;
   logic        op_valid;
   logic        op_ready = 1'b1;
   logic [31:0] op_rs1_data;
   logic [31:0] op_rs2_data;
   logic [4:0]  op_rd;
   logic        wb_valid = 1'b0;
   logic [4:0]  wb_rd = '0;
   logic [31:0] wb_data = '0;
   logic [4:0]  rf_rs1;
   logic [4:0]  rf_rs2;
   logic [31:0] rf_rs1_data;
   logic [31:0] rf_rs2_data;
   logic [4:0]  rf_rd;
   logic [31:0] rf_write_data;
   logic        rf_write_enable;

   int n_total = 0;
   int n_pass  = 0;

   regfile_port_ctrl dut (
      .clk             (clk),
      .resetn          (resetn),
      .iss_valid       (iss_valid),
      .iss_ready       (iss_ready),
      .iss_rs1         (iss_rs1),
      .iss_rs2         (iss_rs2),
      .iss_rd          (iss_rd),
      .op_valid        (op_valid),
      .op_ready        (op_ready),
      .op_rs1_data     (op_rs1_data),
      .op_rs2_data     (op_rs2_data),
      .op_rd           (op_rd),
      .wb_valid        (wb_valid),
      .wb_rd           (wb_rd),
      .wb_data         (wb_data),
      .rf_rs1          (rf_rs1),
      .rf_rs2          (rf_rs2),
      .rf_rs1_data     (rf_rs1_data),
      .rf_rs2_data     (rf_rs2_data),
      .rf_rd           (rf_rd),
      .rf_write_data   (rf_write_data),
      .rf_write_enable (rf_write_enable)
   );

   always #5 clk = ~clk;

   // Register file environment: synchronous write, registered read (old data on same-edge write).
   logic [31:0] mem [32];
   always @(posedge clk) begin
      if (rf_write_enable) mem[rf_rd] <= rf_write_data;
      rf_rs1_data <= mem[rf_rs1];
      rf_rs2_data <= mem[rf_rs2];
   end

   // Architectural register state as seen by software: every nonzero writeback lands.
   logic [31:0] arch [32];
   always @(posedge clk) begin
      if (wb_valid && wb_rd != 5'd0) arch[wb_rd] <= wb_data;
   end

   function automatic logic [31:0] arch_val(input logic [4:0] r);
      return (r == 5'd0) ? 32'd0 : arch[r];
   endfunction

   // Occupancy model: one op being read, one op presented; operands always equal current arch state.
   logic       m_fetch, m_present;
   logic [4:0] f_rs1, f_rs2, f_rd, p_rs1, p_rs2, p_rd;
   logic       m_can;
   assign m_can = !m_fetch && (!m_present || op_ready);

   always @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         m_fetch   <= 1'b0;
         m_present <= 1'b0;
      end else begin
         if (m_fetch) begin
            m_present <= 1'b1;
            p_rs1 <= f_rs1; p_rs2 <= f_rs2; p_rd <= f_rd;
         end else if (m_present && op_ready) begin
            m_present <= 1'b0;
         end
         m_fetch <= iss_valid && m_can;
         if (iss_valid && m_can) begin
            f_rs1 <= iss_rs1; f_rs2 <= iss_rs2; f_rd <= iss_rd;
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
   endtask

   // Per-cycle compare against the model, sampled mid-cycle.
   always @(negedge clk) begin
      if (resetn) begin
         check("iss_ready", 32'(iss_ready), 32'(m_can));
         check("op_valid", 32'(op_valid), 32'(m_present));
         check("rf_we", 32'(rf_write_enable), 32'(wb_valid && wb_rd != 5'd0));
         check("rf_rs1", 32'(rf_rs1), 32'(iss_rs1));
         check("rf_rs2", 32'(rf_rs2), 32'(iss_rs2));
         if (m_present) begin
            check("op_rd", 32'(op_rd), 32'(p_rd));
            check("op_rs1_data", op_rs1_data, arch_val(p_rs1));
            check("op_rs2_data", op_rs2_data, arch_val(p_rs2));
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic v, input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rd);
      iss_valid = v; iss_rs1 = r1; iss_rs2 = r2; iss_rd = rd;
   endtask

   task automatic wb(input logic v, input logic [4:0] rd, input logic [31:0] d);
      wb_valid = v; wb_rd = rd; wb_data = d;
   endtask

   initial begin
      // Clear register file and model through the write port while in reset.
      for (int r = 0; r < 32; r++) begin
         wb(1'b1, 5'(r), 32'd0);
         tick();
      end
      wb(1'b0, 5'd0, 32'd0);
      tick();
      resetn = 1'b1;
      @(negedge clk);
      check("rst_iss_ready", 32'(iss_ready), 32'd1);
      check("rst_op_valid", 32'(op_valid), 32'd0);
      check("rst_rf_we", 32'(rf_write_enable), 32'd0);
      check("rst_op_rd", 32'(op_rd), 32'd0);

      // Plain read after a committed writeback.
      tick(); wb(1'b1, 5'd5, 32'hDEADBEEF);
      tick(); wb(1'b0, 5'd0, 32'd0); issue(1'b1, 5'd5, 5'd0, 5'd9);
      tick(); issue(1'b0, 5'd0, 5'd0, 5'd0);
      @(negedge clk);
      check("plain_fetch_valid", 32'(op_valid), 32'd0);
      tick();
      @(negedge clk);
      check("plain_valid", 32'(op_valid), 32'd1);
      check("plain_rs1", op_rs1_data, 32'hDEADBEEF);
      check("plain_rs2", op_rs2_data, 32'd0);
      check("plain_rd", 32'(op_rd), 32'd9);

      // Writeback in the accept cycle.
      tick(); issue(1'b1, 5'd7, 5'd0, 5'd1); wb(1'b1, 5'd7, 32'h12345678);
      tick(); issue(1'b0, 5'd0, 5'd0, 5'd0); wb(1'b0, 5'd0, 32'd0);
      tick();
      @(negedge clk);
      check("acc_haz_rs1", op_rs1_data, 32'h12345678);

      // Writeback in the fetch cycle.
      tick(); issue(1'b1, 5'd0, 5'd7, 5'd2);
      tick(); issue(1'b0, 5'd0, 5'd0, 5'd0); wb(1'b1, 5'd7, 32'hA5A5A5A5);
      tick(); wb(1'b0, 5'd0, 32'd0);
      @(negedge clk);
      check("fetch_haz_rs2", op_rs2_data, 32'hA5A5A5A5);
      check("fetch_haz_rd", 32'(op_rd), 32'd2);

      // Backpressure with a coherence update while presented.
      tick(); issue(1'b1, 5'd3, 5'd5, 5'd4); op_ready = 1'b0;
      tick(); issue(1'b0, 5'd0, 5'd0, 5'd0);
      tick();
      @(negedge clk);
      check("bp_rs1_before", op_rs1_data, 32'd0);
      check("bp_rs2", op_rs2_data, 32'hDEADBEEF);
      check("bp_iss_ready", 32'(iss_ready), 32'd0);
      tick(); wb(1'b1, 5'd3, 32'h00000001);
      tick(); wb(1'b0, 5'd0, 32'd0);
      @(negedge clk);
      check("bp_rs1_after", op_rs1_data, 32'h00000001);
      check("bp_valid", 32'(op_valid), 32'd1);
      check("bp_rd_stable", 32'(op_rd), 32'd4);
      tick(); op_ready = 1'b1; issue(1'b1, 5'd3, 5'd0, 5'd6);
      @(negedge clk);
      check("bp_release_ready", 32'(iss_ready), 32'd1);
      tick(); issue(1'b0, 5'd0, 5'd0, 5'd0);
      @(negedge clk);
      check("b2b_fetch_valid", 32'(op_valid), 32'd0);
      check("b2b_fetch_ready", 32'(iss_ready), 32'd0);
      tick();
      @(negedge clk);
      check("b2b_valid", 32'(op_valid), 32'd1);
      check("b2b_rs1", op_rs1_data, 32'h00000001);
      check("b2b_rd", 32'(op_rd), 32'd6);

      // x0 is never written and always reads zero.
      tick(); wb(1'b1, 5'd0, 32'hFFFFFFFF); issue(1'b1, 5'd0, 5'd0, 5'd0);
      @(negedge clk);
      check("x0_we", 32'(rf_write_enable), 32'd0);
      tick(); wb(1'b0, 5'd0, 32'd0); issue(1'b0, 5'd0, 5'd0, 5'd0);
      tick();
      @(negedge clk);
      check("x0_rs1", op_rs1_data, 32'd0);
      check("x0_rs2", op_rs2_data, 32'd0);

      // Reset while an operation is being read.
      tick(); issue(1'b1, 5'd5, 5'd7, 5'd3);
      tick(); issue(1'b0, 5'd0, 5'd0, 5'd0);
      resetn = 1'b0;
      #1;
      check("midrst_op_valid", 32'(op_valid), 32'd0);
      check("midrst_op_rs1", op_rs1_data, 32'd0);
      tick(); tick();
      resetn = 1'b1;
      @(negedge clk);
      check("postrst_iss_ready", 32'(iss_ready), 32'd1);
      check("postrst_rf_we", 32'(rf_write_enable), 32'd0);
      tick(); tick();
      @(negedge clk);
      check("postrst_no_op", 32'(op_valid), 32'd0);

      // Back-to-back stream with writebacks racing the reads.
      for (int i = 0; i < 6; i++) begin
         tick(); issue(1'b1, 5'(i + 1), 5'(i + 2), 5'(i + 10)); wb(1'b1, 5'(i + 2), 32'(i * 32'h111));
      end
      tick(); issue(1'b0, 5'd0, 5'd0, 5'd0); wb(1'b0, 5'd0, 32'd0);
      tick(); tick(); tick();
      @(negedge clk);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
